// File: rtl/chan_fifo_bridge.sv
// Maps one host channel onto a show-ahead RX/TX byte FIFO pair; every other channel reads 0x00 and swallows writes.
// Define CHAN_FIFO_STATUS_EN to add the status channel (TX count read, bit0 write flushes both FIFOs).
module chan_fifo_bridge #(
  parameter logic [6:0] FIFO_CHAN   = 7'd0,
  parameter logic [6:0] STATUS_CHAN = 7'd1,
  parameter int         DEPTH_LOG2  = 4
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [6:0] chanAddr_in,
  input  logic [7:0] h2fData_in,
  input  logic       h2fValid_in,
  output logic       h2fReady_out,
  output logic [7:0] f2hData_out,
  output logic       f2hValid_out,
  input  logic       f2hReady_in,
  output logic [7:0] rxData_out,
  output logic       rxValid_out,
  input  logic       rxReady_in,
  input  logic [7:0] txData_in,
  input  logic       txValid_in,
  output logic       txReady_out
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  CW       = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]       FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0]            rxMem [DEPTH];
  logic [7:0]            txMem [DEPTH];
  logic [DEPTH_LOG2-1:0] rxRdPtr, rxWrPtr, txRdPtr, txWrPtr;
  logic [CW-1:0]         rxCount, txCount;

  logic rxFull, rxEmpty, txFull, txEmpty;
  logic selFifo;
  logic rxPush, rxPop, txPush, txPop;

  assign rxFull  = (rxCount == FULL_CNT);
  assign rxEmpty = (rxCount == '0);
  assign txFull  = (txCount == FULL_CNT);
  assign txEmpty = (txCount == '0);

  assign selFifo = (chanAddr_in == FIFO_CHAN);

  // Ready/valid depend only on registered counts, never on the opposite side's handshake
  assign h2fReady_out = selFifo ? !rxFull  : 1'b1;
  assign f2hValid_out = selFifo ? !txEmpty : 1'b1;
  assign rxValid_out  = !rxEmpty;
  assign rxData_out   = rxMem[rxRdPtr];
  assign txReady_out  = !txFull;

`ifdef CHAN_FIFO_STATUS_EN
  logic selStatus;
  logic flush;
  assign selStatus = (chanAddr_in == STATUS_CHAN);
  assign flush     = selStatus && h2fValid_in && h2fData_in[0];
`endif

  always_comb begin
    f2hData_out = 8'h00;
    if (selFifo) begin
      f2hData_out = txMem[txRdPtr];
    end
`ifdef CHAN_FIFO_STATUS_EN
    else if (selStatus) begin
      f2hData_out = 8'(txCount);
    end
`endif
  end

  assign rxPush = selFifo && h2fValid_in && !rxFull;
  assign rxPop  = rxReady_in && !rxEmpty;
  assign txPush = txValid_in && !txFull;
  assign txPop  = selFifo && f2hReady_in && !txEmpty;

  // Storage is never reset; a write during a flush lands in a slot the reset pointers ignore
  always_ff @(posedge clk_in) begin
    if (rxPush) rxMem[rxWrPtr] <= h2fData_in;
    if (txPush) txMem[txWrPtr] <= txData_in;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rxRdPtr <= '0;
      rxWrPtr <= '0;
      rxCount <= '0;
      txRdPtr <= '0;
      txWrPtr <= '0;
      txCount <= '0;
    end else begin
`ifdef CHAN_FIFO_STATUS_EN
      if (flush) begin
        rxRdPtr <= '0;
        rxWrPtr <= '0;
        rxCount <= '0;
        txRdPtr <= '0;
        txWrPtr <= '0;
        txCount <= '0;
      end else begin
`endif
        if (rxPush) rxWrPtr <= rxWrPtr + PTR_ONE;
        if (rxPop)  rxRdPtr <= rxRdPtr + PTR_ONE;
        rxCount <= rxCount + CW'(rxPush) - CW'(rxPop);
        if (txPush) txWrPtr <= txWrPtr + PTR_ONE;
        if (txPop)  txRdPtr <= txRdPtr + PTR_ONE;
        txCount <= txCount + CW'(txPush) - CW'(txPop);
`ifdef CHAN_FIFO_STATUS_EN
      end
`endif
    end
  end

endmodule

// File: tb/tb_chan_fifo_bridge.sv
// Self-checking bench for chan_fifo_bridge; a queue-based model tracks both FIFOs and the channel decode.
module tb_chan_fifo_bridge;

  localparam logic [6:0] FIFO_CHAN   = 7'd0;
  localparam logic [6:0] STATUS_CHAN = 7'd1;
  localparam int         DEPTH_LOG2  = 4;
  localparam int         DEPTH       = 16;
`ifdef CHAN_FIFO_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic [6:0] chan;
  logic [7:0] h2fData;
  logic       h2fValid;
  logic       h2fReady;
  logic [7:0] f2hData;
  logic       f2hValid;
  logic       f2hReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];

  always #10 clk = ~clk;

  chan_fifo_bridge #(
    .FIFO_CHAN(FIFO_CHAN), .STATUS_CHAN(STATUS_CHAN), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk_in(clk), .reset_in(resetN), .chanAddr_in(chan),
    .h2fData_in(h2fData), .h2fValid_in(h2fValid), .h2fReady_out(h2fReady),
    .f2hData_out(f2hData), .f2hValid_out(f2hValid), .f2hReady_in(f2hReady),
    .rxData_out(rxData), .rxValid_out(rxValid), .rxReady_in(rxReady),
    .txData_in(txData), .txValid_in(txValid), .txReady_out(txReady)
  );

  function automatic bit isFifo();
    return chan == FIFO_CHAN;
  endfunction

  function automatic bit isStatus();
    return STATUS_EN && (chan == STATUS_CHAN);
  endfunction

  function automatic logic expH2fReady();
    return isFifo() ? (rxQ.size() < DEPTH) : 1'b1;
  endfunction

  function automatic logic expF2hValid();
    return isFifo() ? (txQ.size() > 0) : 1'b1;
  endfunction

  function automatic logic [7:0] expF2hData();
    if (isFifo()) return (txQ.size() > 0) ? txQ[0] : 8'h00;
    if (isStatus()) return 8'(txQ.size());
    return 8'h00;
  endfunction

  // Advance one clock edge and apply the same transfers to the model
  task automatic tick();
    bit doFlush = isStatus() && h2fValid && h2fData[0];
    bit rxIn    = isFifo() && h2fValid && (rxQ.size() < DEPTH);
    bit rxOut   = rxReady && (rxQ.size() > 0);
    bit txIn    = txValid && (txQ.size() < DEPTH);
    bit txOut   = isFifo() && f2hReady && (txQ.size() > 0);
    logic [7:0] hd = h2fData;
    logic [7:0] td = txData;
    @(posedge clk);
    #1;
    if (doFlush) begin
      rxQ.delete();
      txQ.delete();
    end else begin
      if (rxOut) void'(rxQ.pop_front());
      if (rxIn)  rxQ.push_back(hd);
      if (txOut) void'(txQ.pop_front());
      if (txIn)  txQ.push_back(td);
    end
  endtask

  task automatic idle();
    h2fValid = 1'b0;
    h2fData  = 8'h00;
    f2hReady = 1'b0;
    rxReady  = 1'b0;
    txValid  = 1'b0;
    txData   = 8'h00;
  endtask

  task automatic apply_reset();
    idle();
    chan   = FIFO_CHAN;
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    rxQ.delete();
    txQ.delete();
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    chan = FIFO_CHAN;
    #1;
    vectors++;
    if (rxValid !== 1'b0) begin miscompares++; $display("FAIL reset_rxValid got %b want 0", rxValid); end
    vectors++;
    if (txReady !== 1'b1) begin miscompares++; $display("FAIL reset_txReady got %b want 1", txReady); end
    vectors++;
    if (h2fReady !== 1'b1) begin miscompares++; $display("FAIL reset_h2fReady got %b want 1", h2fReady); end
    vectors++;
    if (f2hValid !== 1'b0) begin miscompares++; $display("FAIL reset_f2hValid got %b want 0", f2hValid); end
    chan = 7'h55;
    #1;
    vectors++;
    if (f2hValid !== 1'b1 || f2hData !== 8'h00 || h2fReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_unmapped got v=%b d=%h r=%b want v=1 d=00 r=1", f2hValid, f2hData, h2fReady);
    end
    chan = STATUS_CHAN;
    #1;
    vectors++;
    if (f2hValid !== 1'b1 || f2hData !== 8'h00 || h2fReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_status got v=%b d=%h r=%b want v=1 d=00 r=1", f2hValid, f2hData, h2fReady);
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] bytesIn [3] = '{8'h11, 8'h22, 8'h33};
    apply_reset();
    chan = FIFO_CHAN;
    h2fValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h2fData = bytesIn[i];
      tick();
      if (i == 0) begin
        vectors++;
        if (rxValid !== 1'b1 || rxData !== 8'h11) begin
          miscompares++;
          $display("FAIL rx_latency got v=%b d=%h want v=1 d=11", rxValid, rxData);
        end
      end
    end
    h2fValid = 1'b0;
    rxReady  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (rxValid !== 1'b1 || rxData !== bytesIn[i]) begin
        miscompares++;
        $display("FAIL rx_order[%0d] got v=%b d=%h want v=1 d=%h", i, rxValid, rxData, bytesIn[i]);
      end
      tick();
    end
    rxReady = 1'b0;
    #1;
    vectors++;
    if (rxValid !== 1'b0) begin miscompares++; $display("FAIL rx_drained got %b want 0", rxValid); end
  endtask

  task automatic test_rx_full();
    logic [7:0] want;
    apply_reset();
    chan = FIFO_CHAN;
    h2fValid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      h2fData = 8'(i);
      tick();
    end
    vectors++;
    if (h2fReady !== 1'b0) begin miscompares++; $display("FAIL rx_full_ready got %b want 0", h2fReady); end
    h2fData = 8'hEE;
    tick();
    vectors++;
    if (h2fReady !== 1'b0 || rxData !== 8'h00) begin
      miscompares++;
      $display("FAIL rx_full_hold got r=%b d=%h want r=0 d=00", h2fReady, rxData);
    end
    rxReady = 1'b1;
    #1;
    vectors++;
    if (h2fReady !== 1'b0) begin miscompares++; $display("FAIL rx_full_same_cycle got %b want 0", h2fReady); end
    tick();
    rxReady = 1'b0;
    vectors++;
    if (h2fReady !== 1'b1 || rxData !== 8'h01) begin
      miscompares++;
      $display("FAIL rx_full_after_pop got r=%b d=%h want r=1 d=01", h2fReady, rxData);
    end
    tick();
    h2fValid = 1'b0;
    vectors++;
    if (h2fReady !== 1'b0) begin miscompares++; $display("FAIL rx_full_17th got %b want 0", h2fReady); end
    rxReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      want = (i < DEPTH - 1) ? 8'(i + 1) : 8'hEE;
      #1;
      vectors++;
      if (rxValid !== 1'b1 || rxData !== want) begin
        miscompares++;
        $display("FAIL rx_full_drain[%0d] got v=%b d=%h want v=1 d=%h", i, rxValid, rxData, want);
      end
      tick();
    end
    rxReady = 1'b0;
  endtask

  task automatic test_status();
    logic [7:0] wantCnt = STATUS_EN ? 8'h02 : 8'h00;
    apply_reset();
    txValid = 1'b1;
    txData  = 8'hA5;
    tick();
    txData  = 8'h5A;
    tick();
    txValid = 1'b0;
    chan = STATUS_CHAN;
    f2hReady = 1'b1;
    #1;
    vectors++;
    if (f2hValid !== 1'b1 || f2hData !== wantCnt) begin
      miscompares++;
      $display("FAIL status_count got v=%b d=%h want v=1 d=%h", f2hValid, f2hData, wantCnt);
    end
    tick();
    chan = FIFO_CHAN;
    #1;
    vectors++;
    if (f2hValid !== 1'b1 || f2hData !== 8'hA5) begin
      miscompares++;
      $display("FAIL tx_read0 got v=%b d=%h want v=1 d=a5", f2hValid, f2hData);
    end
    tick();
    vectors++;
    if (f2hValid !== 1'b1 || f2hData !== 8'h5A) begin
      miscompares++;
      $display("FAIL tx_read1 got v=%b d=%h want v=1 d=5a", f2hValid, f2hData);
    end
    tick();
    f2hReady = 1'b0;
    chan = STATUS_CHAN;
    #1;
    vectors++;
    if (f2hData !== 8'h00) begin miscompares++; $display("FAIL status_empty got %h want 00", f2hData); end
    chan = FIFO_CHAN;
    #1;
    vectors++;
    if (f2hValid !== 1'b0) begin miscompares++; $display("FAIL tx_empty_valid got %b want 0", f2hValid); end
  endtask

  task automatic test_flush();
    apply_reset();
    chan = FIFO_CHAN;
    h2fValid = 1'b1;
    txValid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      h2fData = 8'(i + 1);
      txData  = 8'(8'h40 + i);
      tick();
    end
    chan    = STATUS_CHAN;
    h2fData = 8'h01;
    txData  = 8'h77;
    #1;
    vectors++;
    if (h2fReady !== 1'b1) begin miscompares++; $display("FAIL flush_write_ready got %b want 1", h2fReady); end
    tick();
    idle();
    #1;
    vectors++;
    if (rxValid !== !STATUS_EN) begin
      miscompares++;
      $display("FAIL flush_rxValid got %b want %b", rxValid, !STATUS_EN);
    end
    vectors++;
    if (f2hData !== 8'h00) begin miscompares++; $display("FAIL flush_status got %h want 00", f2hData); end
    chan = FIFO_CHAN;
    #1;
    vectors++;
    if (f2hValid !== !STATUS_EN) begin
      miscompares++;
      $display("FAIL flush_txValid got %b want %b", f2hValid, !STATUS_EN);
    end
  endtask

  task automatic test_unmapped();
    apply_reset();
    chan = 7'h55;
    h2fValid = 1'b1;
    h2fData  = 8'hFF;
    f2hReady = 1'b1;
    #1;
    vectors++;
    if (h2fReady !== 1'b1 || f2hValid !== 1'b1 || f2hData !== 8'h00) begin
      miscompares++;
      $display("FAIL unmapped_io got r=%b v=%b d=%h want r=1 v=1 d=00", h2fReady, f2hValid, f2hData);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rxValid !== 1'b0) begin miscompares++; $display("FAIL unmapped_rx got %b want 0", rxValid); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    chan = FIFO_CHAN;
    h2fValid = 1'b1;
    txValid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h2fData = 8'($urandom);
      txData  = 8'($urandom);
      tick();
    end
    idle();
    #3;
    resetN = 1'b0;
    #2;
    vectors++;
    if (rxValid !== 1'b0 || txReady !== 1'b1 || f2hValid !== 1'b0 || h2fReady !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset got rxV=%b txR=%b f2hV=%b h2fR=%b want 0 1 0 1",
               rxValid, txReady, f2hValid, h2fReady);
    end
    rxQ.delete();
    txQ.delete();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    #1;
  endtask

  task automatic test_random();
    int sel;
    int pH, pR, pT, pF;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) begin
        pH = $urandom_range(10, 95);
        pR = $urandom_range(10, 95);
        pT = $urandom_range(10, 95);
        pF = $urandom_range(10, 95);
      end
      sel = $urandom_range(0, 19);
      if (sel < 14)      chan = FIFO_CHAN;
      else if (sel < 17) chan = STATUS_CHAN;
      else if (sel < 18) chan = 7'h55;
      else               chan = 7'($urandom);
      h2fValid = ($urandom_range(0, 99) < pH);
      h2fData  = 8'($urandom);
      if (chan == STATUS_CHAN && $urandom_range(0, 7) != 0) h2fData[0] = 1'b0;
      f2hReady = ($urandom_range(0, 99) < pF);
      rxReady  = ($urandom_range(0, 99) < pR);
      txValid  = ($urandom_range(0, 99) < pT);
      txData   = 8'($urandom);
      #1;
      vectors++;
      if (h2fReady !== expH2fReady()) begin
        miscompares++;
        $display("FAIL rand_h2fReady cyc %0d got %b want %b", cyc, h2fReady, expH2fReady());
      end
      vectors++;
      if (f2hValid !== expF2hValid()) begin
        miscompares++;
        $display("FAIL rand_f2hValid cyc %0d got %b want %b", cyc, f2hValid, expF2hValid());
      end
      if (expF2hValid()) begin
        vectors++;
        if (f2hData !== expF2hData()) begin
          miscompares++;
          $display("FAIL rand_f2hData cyc %0d chan %h got %h want %h", cyc, chan, f2hData, expF2hData());
        end
      end
      vectors++;
      if (rxValid !== (rxQ.size() > 0)) begin
        miscompares++;
        $display("FAIL rand_rxValid cyc %0d got %b want %b", cyc, rxValid, rxQ.size() > 0);
      end
      if (rxQ.size() > 0) begin
        vectors++;
        if (rxData !== rxQ[0]) begin
          miscompares++;
          $display("FAIL rand_rxData cyc %0d got %h want %h", cyc, rxData, rxQ[0]);
        end
      end
      vectors++;
      if (txReady !== (txQ.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL rand_txReady cyc %0d got %b want %b", cyc, txReady, txQ.size() < DEPTH);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    resetN = 1'b0;
    chan   = FIFO_CHAN;
    idle();
    test_reset();
    test_rx_basic();
    test_rx_full();
    test_status();
    test_flush();
    test_unmapped();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chan_fifo_bridge.md
# chan_fifo_bridge

Channel-side stage that consumes the 7-bit channel address and the host→FPGA / FPGA→host byte pipes produced by the host communication block. It maps one channel onto a pair of show-ahead byte FIFOs: a host-to-application RX FIFO and an application-to-host TX FIFO. An optional status channel reports TX occupancy and accepts a flush command. All other channels read as 0x00 and discard writes, so the host never stalls on an unmapped channel.

## Interface
- FIFO_CHAN, 7'd0, channel number mapped to the FIFOs.
- STATUS_CHAN, 7'd1, channel number of the status/flush register. Must differ from FIFO_CHAN.
- DEPTH_LOG2, 4, log2 of each FIFO's depth. Legal range is 1..7.

Ports:
- clk_in, input, 1, single clock for all logic.
- reset_in, input, 1, asynchronous, active-low reset.
- chanAddr_in, input, 7, currently selected channel.
- h2fData_in, input, 8, host write data.
- h2fValid_in, input, 1, host write byte present.
- h2fReady_out, output, 1, bridge can accept the host byte.
- f2hData_out, output, 8, host read data.
- f2hValid_out, output, 1, host read byte available.
- f2hReady_in, input, 1, host consumes f2hData_out at this edge.
- rxData_out, output, 8, head of the RX FIFO.
- rxValid_out, output, 1, RX FIFO is non-empty.
- rxReady_in, input, 1, application pops the RX head.
- txData_in, input, 8, application byte for the host.
- txValid_in, input, 1, application pushes a byte.
- txReady_out, output, 1, TX FIFO is not full.

## Operation
- A transfer occurs on a rising edge with valid=1 and ready=1, on every port pair.
- Each FIFO has 2^DEPTH_LOG2 entries, read/write pointers of width DEPTH_LOG2 that wrap modulo depth, and a count of width DEPTH_LOG2+1.
- Full means count == depth. Empty means count == 0.
- Decode is combinational on chanAddr_in:
  - FIFO_CHAN:
    - h2fReady_out = !rxFull. Host writes push into RX.
    - f2hValid_out = !txEmpty and f2hData_out = TX head. Host reads pop TX.
  - STATUS_CHAN:
    - Reads return f2hValid_out=1 and f2hData_out = TX count, zero-extended to 8 bits.
    - Writes are always accepted (h2fReady_out=1). If bit0=1, both FIFOs flush: pointers and counts go to 0 at that edge. Other bits are ignored.
  - Any other channel: h2fReady_out=1 and data is discarded. f2hValid_out=1 with f2hData_out=8'h00.
- Application side:
  - rxValid_out = !rxEmpty and rxData_out = RX head.
  - txReady_out = !txFull.
- Head data comes from registered storage. There is no combinational path from any ready input to any data output.
- Simultaneous push and pop on one FIFO:
  - Both take effect and the count is unchanged.
  - Ready/valid are computed only from registered count, so a full FIFO does not accept a push in the same cycle as a pop. An empty FIFO does not present a byte pushed in that same cycle.
- Flush coincident with an RX pop, TX push or TX pop: the flush wins, and the other operation is dropped.
- FIFO contents are not cleared by flush or reset; only pointers and counts are.

## Timing
- While reset_in=0, and immediately after release, both FIFOs are empty. Outputs follow from that state:
  - rxValid_out=0, rxData_out undefined (don't-care)
  - txReady_out=1
  - h2fReady_out=1 on every channel
  - f2hValid_out=0 on FIFO_CHAN; 1 elsewhere
  - f2hData_out: 8'h00 on STATUS_CHAN and unmapped channels
- Reset asserted mid-transfer empties both FIFOs asynchronously. Any in-flight byte is lost.
- Latency from a host write accepted at edge k to rxValid_out=1 is the cycle after edge k (1 cycle). TX push to f2hValid_out=1 is likewise 1 cycle.
- A status read reflects the TX count registered at the previous edge.
- Throughput is one byte per clock per direction. Both directions may run concurrently.

## Configuration
- CHAN_FIFO_STATUS_EN defined: the STATUS_CHAN read and flush behaviour described above is implemented.
- CHAN_FIFO_STATUS_EN undefined: STATUS_CHAN behaves exactly as an unmapped channel (reads 0x00, writes discarded), and no flush logic exists.

## Test plan
- Reset release, chanAddr_in=FIFO_CHAN: rxValid_out=0, txReady_out=1, h2fReady_out=1, f2hValid_out=0.
- Host writes 0x11,0x22,0x33 to FIFO_CHAN on consecutive cycles with rxReady_in=0:
  - rxValid_out=1 one cycle after the first write, with rxData_out=0x11.
  - Popping yields 0x22, then 0x33, then rxValid_out=0.
- DEPTH_LOG2=4, 16 host writes with no pops:
  - h2fReady_out=0 after the 16th.
  - Holding a 17th byte with h2fValid_in=1 gets no transfer.
  - One RX pop restores h2fReady_out=1 on the following cycle, and the 17th byte is accepted.
- App pushes 0xA5,0x5A; host reads STATUS_CHAN:
  - Status read returns 0x02.
  - Reads on FIFO_CHAN then return 0xA5 and 0x5A.
  - A further status read returns 0x00, and f2hValid_out=0 on FIFO_CHAN.
- With 5 bytes in each FIFO, host writes 0x01 to STATUS_CHAN while the app pushes 0x77 in the same cycle: next cycle rxValid_out=0 and the status read is 0x00.
- Host writes 0xFF to channel 0x55 and reads it: write accepted in one cycle and RX unchanged; read returns 0x00 with f2hValid_out=1.
- Reset asserted mid-stream: both FIFOs empty without waiting for a clock edge.
